nv_ram_rwsp_param: RTL and testbench
====================================

// Module: nv_ram_rwsp_param
// PURPOSE
//  Parametrised 1R1W synchronous-pipelined RAM model; next generation of the fixed-size rwsp models.
//  Adds: generic depth/width, address-range checking, read-during-write forwarding,
//  post-reset hardware clear of all entries, and a registered read-valid.
//  Used wherever datapath buffers need an FPGA-inferable RAM with deterministic contents after reset.
// PARAMETERS
//  DEPTH     160  number of entries (any value >= 2, need not be a power of 2)
//  WIDTH     65   data width in bits
//  AW        8    address width; must satisfy 2**AW >= DEPTH
//  BYPASS    1    1: same-cycle write/read to the same address returns the new data; 0: returns old array data
//  INIT_CLR  1    1: zero all entries after reset; 0: no clear, ready immediately
// PORTS
//  clk            in   1      single clock, all logic on rising edge
//  rstn           in   1      asynchronous, active-low reset
//  ra             in   AW     read address
//  re             in   1      read enable; captures ra
//  ore            in   1      output register enable; captures array data into dout
//  dout           out  WIDTH  registered read data
//  dout_vld       out  1      dout holds data from an accepted read
//  wa             in   AW     write address
//  we             in   1      write enable
//  di             in   WIDTH  write data
//  ready          out  1      clear finished; accesses accepted
//  addr_err       out  1      sticky: out-of-range or during-clear access seen
//  pwrbus_ram_pd  in   32     power-down bus; ignored by this model
// BEHAVIOUR
//  Reset values: dout=0, dout_vld=0, ready=0 (ready=1 if INIT_CLR=0), addr_err=0, ra_d=0. Array is not reset.
//  Clear FSM states: IDLE -> CLEAR -> DONE.
//   - IDLE: entered on reset; first clock after rstn deasserts goes to CLEAR (INIT_CLR=1) or DONE (INIT_CLR=0).
//   - CLEAR: writes 0 to entry clr_ptr; clr_ptr counts 0..DEPTH-1. At DEPTH-1 it goes to DONE.
//     So the clear takes exactly DEPTH cycles.
//   - DONE: ready=1. The FSM stays in DONE until reset.
//   - Reset asserted mid-clear: the FSM returns to IDLE, clr_ptr=0, and the clear restarts from entry 0.
//  Any we or re while ready=0 is dropped: no array write, no ra_d capture. addr_err is set.
//  Write: we && ready && wa<DEPTH -> M[wa]<=di on the clock edge. wa>=DEPTH -> no write, addr_err set.
//  Read pipeline, 2 cycles:
//   - Cycle 0: re && ready captures ra into ra_d, and a range/valid tag into vld_d.
//   - Cycle 1: ore captures rd_data into dout and vld_d into dout_vld.
//  re=0 holds ra_d and vld_d. ore=0 holds dout and dout_vld.
//  Read with ra>=DEPTH is accepted, but rd_data is forced to 0, vld_d=0, and addr_err is set.
//  Forwarding (BYPASS=1), cycle 0: re && we && ra==wa, both in range.
//   - fwd flag and fwd_data<=di are registered.
//   - In cycle 1, rd_data=fwd_data, independent of any later write to that address.
//   - A write to ra_d in cycle 1 itself is NOT forwarded; rd_data=M[ra_d], i.e. data before that write.
//  BYPASS=0: rd_data=M[ra_d] in cycle 1; a same-cycle write is visible only if it landed in cycle 0.
//  Simultaneous ore and re: dout takes data for the older ra_d; the new ra is captured for the next ore.
//  addr_err clears only on reset.
// STRUCTURE
//  Shared include nv_ram_defs.vh holds:
//   - nv_clog2 function
//   - FSM state encodings NV_RAM_IDLE/CLEAR/DONE (2-bit)
//   - AW legality check macro
//  One sub-module: nv_ram_clr_fsm.
//   - Parameter DEPTH, AW.
//   - Ports clk, rstn, en, clr_we, clr_addr, ready.
//  The array write port is muxed: clear write when !ready, user write when ready.
//  Array uses (*ram_style="block"*); forward/valid/error logic in flops outside the array.
// TESTING
//  1) DEPTH=160, INIT_CLR=1: release rstn, count cycles. ready rises after exactly 161 clocks.
//     Read all 160 entries -> dout=0, dout_vld=1.
//  2) write 0x1_2345_6789_ABCD_EF01 to wa=159, read ra=159 with re then ore -> dout equals data 2 cycles later.
//  3) BYPASS=1: same cycle we=1 wa=5 di=0xAA and re=1 ra=5, old M[5]=0x55 -> dout=0xAA.
//     Repeat with BYPASS=0 -> dout=0x55.
//  4) wa=200, we=1 -> no entry changes, addr_err=1.
//     Read ra=170 -> dout=0, dout_vld=0.
//  5) Pulse rstn low at clear cycle 80 -> ready low again; ready rises 161 clocks after the second release.
//     Write during clear is dropped; addr_err=1.
//  6) ore held 0 for 10 cycles while re toggles -> dout/dout_vld unchanged; first ore returns last captured ra.

Source files
------------

// File: rtl/nv_ram_rwsp_param_pkg.sv
// rtl/nv_ram_rwsp_param_pkg.sv - shared types and helpers for the parametrised rwsp RAM
package nv_ram_rwsp_param_pkg;

    // Clear sequencer state encodings
    typedef enum logic [1:0] {
        NV_RAM_IDLE  = 2'd0,
        NV_RAM_CLEAR = 2'd1,
        NV_RAM_DONE  = 2'd2
    } nv_ram_state_e;

    // Ceiling log2, returns at least 1 so a 1-bit address is the minimum
    function automatic int nv_clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

    // Address width legality: the address must be able to name every entry
    function automatic bit nv_aw_ok(input int depth, input int aw);
        return (depth >= 2) && (aw >= nv_clog2(depth));
    endfunction

endpackage

// File: rtl/nv_ram_clr_fsm.sv
// rtl/nv_ram_clr_fsm.sv - post-reset sequencer that zeroes every RAM entry once
module nv_ram_clr_fsm
    import nv_ram_rwsp_param_pkg::*;
#(
    parameter int DEPTH = 160,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    nv_ram_state_e state;

    // One pass over the array after reset; a reset at any point restarts from entry 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= NV_RAM_IDLE;
            clr_we   <= 1'b0;
            clr_addr <= '0;
            ready    <= ~en;
        end else begin
            case (state)
                NV_RAM_IDLE: begin
                    clr_addr <= '0;
                    if (en) begin
                        state  <= NV_RAM_CLEAR;
                        clr_we <= 1'b1;
                    end else begin
                        state  <= NV_RAM_DONE;
                        clr_we <= 1'b0;
                        ready  <= 1'b1;
                    end
                end
                NV_RAM_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state  <= NV_RAM_DONE;
                        clr_we <= 1'b0;
                        ready  <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                NV_RAM_DONE: begin
                    clr_we <= 1'b0;
                    ready  <= 1'b1;
                end
                default: begin
                    state    <= NV_RAM_IDLE;
                    clr_we   <= 1'b0;
                    clr_addr <= '0;
                    ready    <= ~en;
                end
            endcase
        end
    end

endmodule

// File: rtl/nv_ram_rwsp_param.sv
// rtl/nv_ram_rwsp_param.sv - parametrised 1R1W pipelined RAM with clear, range check and forwarding
module nv_ram_rwsp_param
    import nv_ram_rwsp_param_pkg::*;
#(
    parameter int DEPTH    = 160,
    parameter int WIDTH    = 65,
    parameter int AW       = 8,
    parameter int BYPASS   = 1,
    parameter int INIT_CLR = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    output logic             ready,
    output logic             addr_err,
    input  logic [31:0]      pwrbus_ram_pd
);

    // Extra bit so DEPTH == 2**AW still compares correctly
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    if (!nv_aw_ok(DEPTH, AW)) begin : g_aw_illegal
        $error("nv_ram_rwsp_param: AW too small for DEPTH");
    end

    // Power-down bus has no effect in this model
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    nv_ram_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rstn     (rstn),
        .en       (INIT_CLR != 0),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    logic wa_ok;
    logic ra_ok;
    logic wr_acc;
    logic rd_acc;
    logic fwd_hit;

    assign wa_ok   = {1'b0, wa} < DEPTH_W;
    assign ra_ok   = {1'b0, ra} < DEPTH_W;
    assign wr_acc  = ready && we && wa_ok;
    assign rd_acc  = ready && re;
    assign fwd_hit = (BYPASS != 0) && wr_acc && rd_acc && ra_ok && (ra == wa);

    // Single write port: clear sequencer owns it until ready, then the user
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    assign mem_we = ready ? wr_acc : clr_we;
    assign mem_wa = ready ? wa : clr_addr;
    assign mem_wd = ready ? di : '0;

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mem_q;

    // Read-first block RAM: a read sees the array as it was before this edge's write
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        if (rd_acc && ra_ok) begin
            mem_q <= mem[ra];
        end
    end

    logic             vld_d;
    logic             fwd;
    logic [WIDTH-1:0] fwd_data;
    logic [WIDTH-1:0] rd_data;

    // Stage-0 side flops: range tag and captured forward data travel with the read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_d    <= 1'b0;
            fwd      <= 1'b0;
            fwd_data <= '0;
        end else if (rd_acc) begin
            vld_d <= ra_ok;
            fwd   <= fwd_hit;
            if (fwd_hit) begin
                fwd_data <= di;
            end
        end
    end

    assign rd_data = !vld_d ? '0 : (fwd ? fwd_data : mem_q);

    // Output register, advanced only by ore
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (ore) begin
            dout     <= rd_data;
            dout_vld <= vld_d;
        end
    end

    // Sticky error: access before ready or out-of-range address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_err <= 1'b0;
        end else if ((!ready && (we || re)) ||
                     (ready && we && !wa_ok) ||
                     (ready && re && !ra_ok)) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// tb/tb_nv_ram_rwsp_param.sv - directed self-checking bench for nv_ram_rwsp_param
module tb_nv_ram_rwsp_param;

    localparam int DEPTH = 160;
    localparam int WIDTH = 65;
    localparam int AW    = 8;

    logic             clk;
    logic             rstn;
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic [31:0]      pwrbus_ram_pd;

    logic [WIDTH-1:0] dout1, dout0;
    logic             vld1, vld0;
    logic             rdy1, rdy0;
    logic             err1, err0;

    int n_chk;
    int n_pass;

    nv_ram_rwsp_param #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .BYPASS(1), .INIT_CLR(1)
    ) dut (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
        .dout(dout1), .dout_vld(vld1), .wa(wa), .we(we), .di(di),
        .ready(rdy1), .addr_err(err1), .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    nv_ram_rwsp_param #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .BYPASS(0), .INIT_CLR(1)
    ) dut_nobyp (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
        .dout(dout0), .dout_vld(vld0), .wa(wa), .we(we), .di(di),
        .ready(rdy0), .addr_err(err0), .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        re = 1'b0; ore = 1'b0; we = 1'b0;
        ra = '0;   wa = '0;    di = '0;
    endtask

    // Releases rstn just after an edge and returns the number of edges until ready
    task automatic release_and_count(output int cnt);
        rstn = 1'b1;
        cnt = 0;
        while (!rdy1 && cnt < 400) begin
            tick();
            cnt = cnt + 1;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        we = 1'b1; wa = a; di = d;
        tick();
        we = 1'b0;
    endtask

    // re then ore on the following cycle
    task automatic rd(input logic [AW-1:0] a);
        re = 1'b1; ra = a;
        tick();
        re = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
    endtask

    localparam logic [WIDTH-1:0] BIG = 65'h1_2345_6789_ABCD_EF01;

    initial begin
        int cnt;
        int good;
        n_chk = 0;
        n_pass = 0;
        pwrbus_ram_pd = 32'hDEAD_BEEF;
        rstn = 1'b0;
        idle_in();
        repeat (3) tick();

        chk("rst_ready", {64'd0, rdy1}, '0);
        chk("rst_dout", dout1, '0);
        chk("rst_vld", {64'd0, vld1}, '0);
        chk("rst_err", {64'd0, err1}, '0);

        // 1) clear length and cleared contents
        release_and_count(cnt);
        chk("clr_cycles", WIDTH'(cnt), WIDTH'(161));
        chk("clr_ready_nobyp", {64'd0, rdy0}, 65'd1);
        good = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            re  = (i < DEPTH);
            ra  = AW'(i);
            ore = (i > 0);
            tick();
            if (i > 0 && dout1 == '0 && vld1 == 1'b1) good = good + 1;
        end
        idle_in();
        chk("clr_all_zero", WIDTH'(good), WIDTH'(DEPTH));
        chk("clr_no_err", {64'd0, err1}, '0);

        // 2) wide data at the last entry
        wr(8'd159, BIG);
        rd(8'd159);
        chk("big_dout", dout1, BIG);
        chk("big_vld", {64'd0, vld1}, 65'd1);

        // 3) same-cycle read/write to the same address
        wr(8'd5, 65'h55);
        we = 1'b1; wa = 8'd5; di = 65'hAA;
        re = 1'b1; ra = 8'd5;
        tick();
        idle_in();
        ore = 1'b1;
        tick();
        ore = 1'b0;
        chk("fwd_byp1", dout1, 65'hAA);
        chk("fwd_byp0", dout0, 65'h55);
        rd(8'd5);
        chk("after_fwd_byp0", dout0, 65'hAA);

        // write landing in the ore cycle is not seen by that read
        re = 1'b1; ra = 8'd7;
        tick();
        re = 1'b0; ore = 1'b1; we = 1'b1; wa = 8'd7; di = 65'h77;
        tick();
        idle_in();
        chk("late_wr_byp1", dout1, '0);
        chk("late_wr_byp0", dout0, '0);
        rd(8'd7);
        chk("late_wr_next", dout1, 65'h77);

        // 4) out-of-range write and read
        chk("err_before_oor", {64'd0, err1}, '0);
        wr(8'd200, {WIDTH{1'b1}});
        chk("oor_wr_err", {64'd0, err1}, 65'd1);
        rd(8'd72);
        chk("oor_wr_no_alias", dout1, '0);
        rd(8'd170);
        chk("oor_rd_dout", dout1, '0);
        chk("oor_rd_vld", {64'd0, vld1}, '0);

        // 5) reset pulse in the middle of the clear
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (40) tick();
        chk("mid_clear_err0", {64'd0, err1}, '0);
        wr(8'd3, 65'h33);
        chk("clear_wr_err", {64'd0, err1}, 65'd1);
        chk("clear_wr_err_nobyp", {64'd0, err0}, 65'd1);
        repeat (39) tick();
        chk("mid_clear_busy", {64'd0, rdy1}, '0);
        rstn = 1'b0;
        tick();
        chk("pulse_ready", {64'd0, rdy1}, '0);
        chk("pulse_err_clr", {64'd0, err1}, '0);
        release_and_count(cnt);
        chk("reclr_cycles", WIDTH'(cnt), WIDTH'(161));
        rd(8'd159);
        chk("reclr_159", dout1, '0);
        rd(8'd3);
        chk("reclr_3", dout1, '0);

        // 6) ore held low while re toggles
        wr(8'd10, 65'h1010);
        wr(8'd11, 65'h1111);
        wr(8'd12, 65'h1212);
        rd(8'd10);
        good = 0;
        for (int i = 0; i < 10; i++) begin
            re = (i % 2 == 0);
            ra = (i == 8) ? 8'd12 : 8'd11;
            tick();
            if (dout1 == 65'h1010 && vld1 == 1'b1) good = good + 1;
        end
        idle_in();
        chk("hold_dout", WIDTH'(good), WIDTH'(10));
        ore = 1'b1;
        tick();
        ore = 1'b0;
        chk("hold_last_ra", dout1, 65'h1212);
        chk("hold_last_vld", {64'd0, vld1}, 65'd1);
        chk("final_err", {64'd0, err1}, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
